// File: rtl/crc_pkg.sv
// Shared types and helpers for the streaming CRC engine.
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Reverses the low w bits of x; result lands in the low w bits.
  function automatic logic [31:0] bit_rev(
    input logic [31:0] x,
    input int          w
  );
    logic [31:0] r;
    int          j;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      j = w - 1 - i;
      if (j >= 0) r[i] = x[j[4:0]];
    end
    return r;
  endfunction

endpackage

// File: rtl/crc_stream_if.sv
// Valid/ready word stream feeding the CRC engine.
interface crc_stream_if #(
  parameter int DATA_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;

  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ready
  );
endinterface

// File: rtl/crc_step.sv
// Combinational BPC-bit CRC update, MSB of i_bits enters first.
module crc_step #(
  parameter int               CRC_W = 8,
  parameter int               BPC   = 1,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(7)
) (
  input  logic [CRC_W-1:0] i_acc,
  input  logic [BPC-1:0]   i_bits,
  output logic [CRC_W-1:0] o_acc
);

  logic [CRC_W-1:0] w_a;
  logic             w_fb;

  always_comb begin
    w_a  = i_acc;
    w_fb = 1'b0;
    for (int k = BPC - 1; k >= 0; k--) begin
      w_fb = w_a[CRC_W-1] ^ i_bits[k];
      w_a  = {w_a[CRC_W-2:0], 1'b0}
           ^ (w_fb ? POLY : '0);
    end
    o_acc = w_a;
  end

endmodule

// File: rtl/crc_stream.sv
// Streaming CRC: accepts a word, shifts it in BPC bits
// per cycle, and publishes the frame CRC on in_last.
module crc_stream
  import crc_pkg::*;
#(
  parameter int          CRC_W       = 8,
  parameter int          DATA_W      = 8,
  parameter int          BPC         = 1,
  parameter logic [31:0] POLY        = 32'h07,
  parameter logic [31:0] INIT        = 32'h0,
  parameter logic [31:0] XOR_OUT     = 32'h0,
  parameter bit          REFLECT_IN  = 1'b0,
  parameter bit          REFLECT_OUT = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  crc_stream_if.slave      s_in,
  output logic [CRC_W-1:0] crc,
  output logic             crc_valid,
  output logic             busy
);

  localparam int STEPS = DATA_W / BPC;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);
  localparam logic [CRC_W-1:0] P = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] I = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] X = XOR_OUT[CRC_W-1:0];

  state_e            r_state;
  state_e            w_next;
  logic [CRC_W-1:0]  r_acc;
  logic [CRC_W-1:0]  r_crc;
  logic [CRC_W-1:0]  w_acc_step;
  logic [CRC_W-1:0]  w_res;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_din;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last;
  logic              r_live;
  logic              r_valid;
  logic              w_ready;
  logic              w_accept;
  logic              w_final;

  // LSB-first feed is done by reversing once at accept time.
  assign w_din = REFLECT_IN
    ? DATA_W'(bit_rev(32'(s_in.in_data), DATA_W))
    : s_in.in_data;

  assign w_res = (REFLECT_OUT
    ? CRC_W'(bit_rev(32'(r_acc), CRC_W))
    : r_acc) ^ X;

  assign w_accept      = s_in.in_valid & w_ready;
  assign w_final       = (r_cnt == LAST_CNT);
  assign s_in.in_ready = w_ready;
  assign crc           = r_crc;
  assign crc_valid     = r_valid;

  crc_step #(
    .CRC_W (CRC_W),
    .BPC   (BPC),
    .POLY  (P)
  ) u_step (
    .i_acc  (r_acc),
    .i_bits (r_data[DATA_W-1 -: BPC]),
    .o_acc  (w_acc_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clr) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE:    if (w_accept) w_next = SHIFT;
        SHIFT:   if (w_final)
                   w_next = r_last ? DONE : IDLE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // r_live holds in_ready low until the first edge out of reset.
  always_comb begin
    w_ready = 1'b0;
    busy    = 1'b1;
    unique case (r_state)
      IDLE: begin
        w_ready = r_live & ~clr;
        busy    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= I;
      r_cnt   <= '0;
      r_crc   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_last  <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_live  <= 1'b1;
      r_valid <= 1'b0;
      if (clr) begin
        r_acc <= I;
        r_cnt <= '0;
      end else begin
        unique case (r_state)
          IDLE: if (w_accept) begin
            r_data <= w_din;
            r_last <= s_in.in_last;
            r_cnt  <= '0;
          end
          SHIFT: begin
            r_acc  <= w_acc_step;
            r_data <= r_data << BPC;
            r_cnt  <= w_final ? '0 : r_cnt + 1'b1;
          end
          DONE: begin
            r_crc   <= w_res;
            r_valid <= 1'b1;
            r_acc   <= I;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/crc_stream.md
CRC_STREAM -- requirements
Module: crc_stream

Interface
REQ-001 SHALL have parameter CRC_W, default 8: CRC register width, legal 8..32.
REQ-002 SHALL have parameter DATA_W, default 8: input word width, legal 8, 16 or 32.
REQ-003 SHALL have parameter BPC, default 1: bits processed per cycle, a power of two that divides DATA_W.
REQ-004 SHALL have parameter POLY, default 8'h07: generator polynomial, normal form, x^CRC_W term implicit.
REQ-005 SHALL have parameter INIT, default 0: accumulator value at reset, after clr and after each completed frame.
REQ-006 SHALL have parameter XOR_OUT, default 0: value XORed into the result.
REQ-007 SHALL have parameter REFLECT_IN, default 0: 1 feeds each word LSB-first, 0 feeds it MSB-first.
REQ-008 SHALL have parameter REFLECT_OUT, default 0: 1 bit-reverses the accumulator before the XOR_OUT step.
REQ-009 SHALL have port clk, input, 1 bit: clock; all logic on the rising edge.
REQ-010 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-011 SHALL have port clr, input, 1 bit: synchronous abort and reinitialise.
REQ-012 SHALL have port in_valid, input, 1 bit: in_data and in_last are valid.
REQ-013 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-014 SHALL have port in_data, input, DATA_W bits: data word.
REQ-015 SHALL have port in_last, input, 1 bit: the word is the final word of its frame.
REQ-016 SHALL have port crc, output, CRC_W bits: final CRC of the last completed frame.
REQ-017 SHALL have port crc_valid, output, 1 bit: one-cycle pulse marking an update of crc.
REQ-018 SHALL have port busy, output, 1 bit: high while the block is not in IDLE.

Function
REQ-019 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-020 SHALL drive in_ready = 1 only in IDLE with clr low; a word is accepted when in_valid and in_ready are both high.
REQ-021 SHALL, on accept, register in_data and in_last, load bit counter 0 and go to SHIFT.
REQ-022 SHALL, in SHIFT, feed BPC bits per cycle into the accumulator: MSB-first when REFLECT_IN=0, LSB-first when REFLECT_IN=1.
REQ-023 SHALL apply per input bit b: fb = acc[CRC_W-1]^b; acc = {acc[CRC_W-2:0],0} ^ (fb ? POLY : 0).
REQ-024 SHALL remain in SHIFT for exactly DATA_W/BPC cycles per word; the counter is sized ceil(log2(DATA_W/BPC)) bits and wraps to 0 on the final step.
REQ-025 SHALL, after the final step of a word whose in_last=0, return to IDLE with the accumulator retained.
REQ-026 SHALL, after the final step of a word whose in_last=1, go to DONE.
REQ-027 SHALL, in DONE (1 cycle), load crc = (REFLECT_OUT ? rev(acc) : acc) ^ XOR_OUT, pulse crc_valid for that cycle, reload acc = INIT and go to IDLE.
REQ-028 SHALL give latency from the accept edge to the crc_valid pulse of DATA_W/BPC+1 cycles for a single-word frame, and a sustained throughput of one word per DATA_W/BPC+1 cycles.
REQ-029 SHALL hold crc stable between crc_valid pulses.
REQ-030 SHALL treat clr as higher priority than any other event in any state: acc = INIT, state = IDLE, counter = 0, no crc_valid pulse, crc unchanged, no accept in that cycle.
REQ-031 SHALL ignore in_valid while in_ready = 0; an upstream source holds its word until accepted.

Reset
REQ-032 SHALL on rst_n low immediately set state = IDLE, acc = INIT, counter = 0, crc = 0, crc_valid = 0, busy = 0 and in_ready = 0.
REQ-033 SHALL drive in_ready high from the first clk edge after rst_n deasserts.
REQ-034 SHALL discard any partial frame when reset asserts mid-frame, with no crc_valid pulse.

Structure
REQ-035 SHALL place the FSM state enum and a bit-reverse function in the shared package crc_pkg.
REQ-036 SHALL contain one sub-module crc_step, a combinational BPC-bit update of the accumulator parameterised by CRC_W, POLY and BPC.

Verification
REQ-037 SHALL test defaults with the frame "123456789" (0x31..0x39, last on 0x39) -> crc = 0xF4, crc_valid pulse 1 cycle.
REQ-038 SHALL test CRC_W=16, POLY=0x1021, INIT=0xFFFF, DATA_W=8 with "123456789" -> 0x29B1; also BPC=4 -> 0x29B1 with 3 cycles per word.
REQ-039 SHALL test CRC_W=32, POLY=0x04C11DB7, INIT/XOR_OUT=0xFFFFFFFF, REFLECT_IN=REFLECT_OUT=1, DATA_W=32 with "123456789" packed LSB-first over 3 words (last word padded per the test plan) -> the value expected by the model; the DATA_W=8 byte stream -> 0xCBF43926.
REQ-040 SHALL test clr asserted in mid-SHIFT of word 5, followed by a full resend of "123456789" -> no pulse for the aborted frame, then crc = 0xF4.
REQ-041 SHALL test rst_n low for 1 cycle mid-frame -> all outputs at reset values; the following frame -> 0xF4.
REQ-042 SHALL test in_valid held high back-to-back across two frames -> in_ready low for DATA_W/BPC cycles per word, two crc_valid pulses, each crc = 0xF4.
